// File: rtl/writeback_unit.sv
// Writeback stage: picks the result, extracts load data, waits for the
// memory response and drives the registered register-file write port.
module writeback_unit #(
  parameter int XLEN = 32,
  parameter int RAW  = 5,
  parameter int OFFW = $clog2(XLEN / 8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [1:0]      ResultSrcW,
  input  logic [2:0]      funct3W,
  input  logic [OFFW-1:0] addr_lo,
  input  logic [XLEN-1:0] ALU_ResultW,
  input  logic [XLEN-1:0] ReadDataW,
  input  logic [XLEN-1:0] PCPlus4W,
  input  logic [XLEN-1:0] ImmW,
  input  logic [RAW-1:0]  RD_W,
  input  logic            RegWriteW,
  input  logic            mem_rsp_valid,
  output logic            stall_out,
  output logic            rf_we,
  output logic [RAW-1:0]  rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            byp_valid,
  output logic [RAW-1:0]  byp_rd,
  output logic [XLEN-1:0] byp_data,
  output logic [63:0]     instret,
  output logic [31:0]     stall_cnt
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [OFFW-1:0] HMASK = ~OFFW'(1);
  localparam logic [OFFW-1:0] WMASK = ~OFFW'(3);

  state_t          state;
  state_t          state_n;
  logic [XLEN-1:0] bsh;
  logic [XLEN-1:0] hsh;
  logic [XLEN-1:0] wsh;
  logic [XLEN-1:0] ld;
  logic [XLEN-1:0] result;
  logic            is_load;
  logic            retire;
  logic            wr;

  // Align the addressed byte, halfword and word lanes down to bit 0
  assign bsh = ReadDataW >> {addr_lo, 3'b000};
  assign hsh = ReadDataW >> {addr_lo & HMASK, 3'b000};
  assign wsh = ReadDataW >> {addr_lo & WMASK, 3'b000};

  assign is_load   = (ResultSrcW == 2'b01);
  assign stall_out = rst & in_valid & is_load & ~mem_rsp_valid;
  assign retire    = in_valid & ~stall_out;
  assign wr        = retire & RegWriteW & (RD_W != '0);

  // Size and sign handling of the load lane
  always_comb begin
    ld = ReadDataW;
    unique case (funct3W)
      3'b000: ld = XLEN'($signed(bsh[7:0]));
      3'b001: ld = XLEN'($signed(hsh[15:0]));
      3'b010: ld = XLEN'($signed(wsh[31:0]));
      3'b011: ld = (XLEN == 64) ? ReadDataW
                                : XLEN'($signed(wsh[31:0]));
      3'b100: ld = XLEN'(bsh[7:0]);
      3'b101: ld = XLEN'(hsh[15:0]);
      3'b110: ld = (XLEN == 64) ? XLEN'(wsh[31:0])
                                : XLEN'($signed(wsh[31:0]));
      3'b111: ld = ReadDataW;
    endcase
  end

  // Result select
  always_comb begin
    result = ALU_ResultW;
    unique case (ResultSrcW)
      2'b00: result = ALU_ResultW;
      2'b01: result = ld;
      2'b10: result = PCPlus4W;
      2'b11: result = ImmW;
    endcase
  end

  // Load-wait state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Enter WAIT on a stalling load, leave once the data is consumed
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (stall_out)  state_n = S_WAIT;
      S_WAIT: if (!stall_out) state_n = S_IDLE;
    endcase
  end

  // Register-file write port and bypass copy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      byp_valid <= 1'b0;
      byp_rd    <= '0;
      byp_data  <= '0;
    end else begin
      rf_we <= wr;
      if (wr) begin
        rf_waddr  <= RD_W;
        rf_wdata  <= result;
        byp_valid <= 1'b1;
        byp_rd    <= RD_W;
        byp_data  <= result;
      end
    end
  end

  // Retire and load-wait counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret   <= '0;
      stall_cnt <= '0;
    end else begin
      if (retire)
        instret <= instret + 64'd1;
      if (stall_out && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; the only legal values are 32 and 64.
REQ-002 Parameter RAW, default 5, register-address width.
REQ-003 Parameter OFFW, default log2(XLEN/8), width of the byte-offset input.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  an instruction is present in the writeback stage.
REQ-007 ResultSrcW  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate.
REQ-008 funct3W  in  3  load size/sign code, used only when ResultSrcW=01.
REQ-009 addr_lo  in  OFFW  low bits of the load address (ALU result).
REQ-010 ALU_ResultW, ReadDataW, PCPlus4W, ImmW  in  XLEN each  candidate results.
REQ-011 RD_W  in  RAW  destination register; RegWriteW  in  1  write enable.
REQ-012 mem_rsp_valid  in  1  ReadDataW is valid this cycle.
REQ-013 stall_out  out  1  hold upstream stages; load data not yet returned.
REQ-014 rf_we  out  1, rf_waddr  out  RAW, rf_wdata  out  XLEN  registered register-file write port.
REQ-015 byp_valid  out  1, byp_rd  out  RAW, byp_data  out  XLEN  last-committed-write bypass.
REQ-016 instret  out  64  retired-instruction counter; stall_cnt  out  32  load-wait cycle counter.

Function
REQ-017 Select result: 00 ALU_ResultW; 01 extracted load; 10 PCPlus4W; 11 ImmW.
REQ-018 Load extraction: byte lane = addr_lo; halfword lane = addr_lo[OFFW-1:1]; word lane = addr_lo[OFFW-1:2] (XLEN=64).
REQ-019 funct3W mapping: 000 LB sign-extend; 001 LH sign-extend; 010 LW sign-extend to XLEN; 100 LBU zero-extend; 101 LHU zero-extend.
REQ-020 funct3W 110 LWU zero-extend and 011 LD full word when XLEN=64; when XLEN=32 both are treated as LW.
REQ-021 funct3W 111 is treated as a full-width load with no extension.
REQ-022 stall_out = in_valid & (ResultSrcW==01) & !mem_rsp_valid, combinational.
REQ-023 FSM state IDLE: on a stalling load go to WAIT; otherwise stay in IDLE.
REQ-024 FSM state WAIT: stall_out follows REQ-022; on mem_rsp_valid go to IDLE in the same cycle the data is consumed.
REQ-025 While stall_out=1, upstream holds all inputs stable; the block ignores input changes and does not retire.
REQ-026 Retire = in_valid & !stall_out; instret increments by 1 per retire and wraps modulo 2^64.
REQ-027 stall_cnt increments on every stall_out=1 cycle and saturates at 0xFFFFFFFF.
REQ-028 Latency is one cycle: a retire in cycle N with RegWriteW=1 and RD_W!=0 gives rf_we=1 with rf_waddr/rf_wdata in cycle N+1.
REQ-029 Otherwise rf_we=0 in N+1; rf_waddr/rf_wdata hold their previous values.
REQ-030 A write to RD_W=0 is suppressed (rf_we=0) but still counts as a retire.
REQ-031 The bypass registers load the same values as the write port on every rf write and hold them until the next write; byp_valid=1 after the first write.
REQ-032 mem_rsp_valid while no load is pending is ignored.
REQ-033 A load arriving with mem_rsp_valid=1 in the same cycle does not stall and does not enter WAIT.

Reset
REQ-034 rst=0 asynchronously forces: FSM to IDLE; rf_we, byp_valid to 0; rf_waddr, rf_wdata, byp_rd, byp_data to 0; instret and stall_cnt to 0.
REQ-035 While rst=0, stall_out is 0 regardless of inputs.
REQ-036 Reset asserted during WAIT abandons the pending load with no write.
REQ-037 The first retire may occur on the first rising edge after rst deasserts.

Verification
REQ-038 ALU op, RD_W=5, ALU_ResultW=0x1234, RegWriteW=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, byp_valid=1, instret=1.
REQ-039 LB, addr_lo=3, ReadDataW=0x80FF_0000, rsp valid same cycle -> rf_wdata=0xFFFFFF80, stall_out never asserted; LBU at the same address -> 0x00000080.
REQ-040 LH, addr_lo=2, mem_rsp_valid low for 3 cycles, then ReadDataW=0x8001_0000 -> stall_out=1 for 3 cycles, stall_cnt=3, single write of 0xFFFF8001, instret +1.
REQ-041 RD_W=0, RegWriteW=1, PC+4 select -> rf_we=0, bypass unchanged, instret +1.
REQ-042 rst pulsed low in the 2nd WAIT cycle -> all outputs 0 immediately, no write after release, next instruction retires normally.
REQ-043 XLEN=64: LW, addr_lo=4, ReadDataW=0x8000_0000_0000_0000 -> 0xFFFFFFFF80000000; LWU -> 0x0000000080000000.
